// File: rtl/updn_counter_param_if.sv
// Control/status bundle for updn_counter_param: configuration and strobes in, count and flags out.
// en and load are per-cycle strobes sampled on every rising edge. There is no ready: the counter accepts one update every cycle.
interface updn_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             dir;
  logic [WIDTH-1:0] step;
  logic             mode;
  logic [WIDTH-1:0] min_val;
  logic [WIDTH-1:0] max_val;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             at_max;
  logic             at_min;
  logic             wrap;
  logic             cfg_err;

  modport master (
    output en, dir, step, mode, min_val, max_val, load, load_val,
    input  count, at_max, at_min, wrap, cfg_err
  );

  modport slave (
    input  en, dir, step, mode, min_val, max_val, load, load_val,
    output count, at_max, at_min, wrap, cfg_err
  );
endinterface

// File: rtl/updn_counter_param.sv
// Parametrised up/down counter bounded by a programmable [min_val, max_val] window.
// It supports a step size, a synchronous load, and either wrap or saturate behaviour at the limits.
module updn_counter_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  updn_counter_param_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic             wrap_q;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  // One extra bit keeps count+step and min_val+step from aliasing back into the window.
  logic [WIDTH:0]   up_sum;
  logic [WIDTH:0]   dn_thr;
  logic             up_fits;
  logic             dn_fits;
  logic             cfg_err;
  logic             active;

  assign cfg_err = bus.min_val > bus.max_val;
  assign up_sum  = {1'b0, count_q} + {1'b0, bus.step};
  assign dn_thr  = {1'b0, bus.min_val} + {1'b0, bus.step};
  assign up_fits = up_sum <= {1'b0, bus.max_val};
  assign dn_fits = {1'b0, count_q} >= dn_thr;
  assign active  = bus.en && !cfg_err && (bus.step != '0);

  always_comb begin
    count_nxt = count_q;
    wrap_nxt  = 1'b0;
    if (bus.load) begin
      count_nxt = bus.load_val;
    end else if (active) begin
      if (!bus.dir) begin
        if (up_fits) begin
          count_nxt = up_sum[WIDTH-1:0];
        end else if (!bus.mode) begin
          count_nxt = bus.min_val;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = bus.max_val;
        end
      end else begin
        if (dn_fits) begin
          count_nxt = count_q - bus.step;
        end else if (!bus.mode) begin
          count_nxt = bus.max_val;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = bus.min_val;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VAL;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_nxt;
      wrap_q  <= wrap_nxt;
    end
  end

  assign bus.count   = count_q;
  assign bus.wrap    = wrap_q;
  assign bus.at_max  = count_q == bus.max_val;
  assign bus.at_min  = count_q == bus.min_val;
  assign bus.cfg_err = cfg_err;

endmodule
